// File: rtl/spi_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave: mode-0 SPI responder with TX holding register and RX buffer.
// Define SPI_SLAVE_RX_FIFO_EN to replace the RX holding register by a 4-deep FIFO.
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       overrun,
  input  logic       clear_overrun,
  output logic       busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, SELECTED = 1'b1} state_t;

  // Synchronizers reset to 0 so a CS held low through reset never looks idle.
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic cs_s, sclk_s, mosi_s, cs_fall, sclk_rise, sclk_fall;
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  state_t     state_q, state_d;
  logic       armed_q, armed_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_empty_q, tx_empty_d;
  logic       shifter_load, push;

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      bit_cnt_q  <= 4'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
      tx_buf_q   <= 8'h00;
      tx_empty_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_empty_q <= tx_empty_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q | cs_s;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    tx_buf_d     = tx_buf_q;
    tx_empty_d   = tx_empty_q;
    shifter_load = 1'b0;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d      = SELECTED;
          bit_cnt_d    = 4'd0;
          shifter_load = 1'b1;
        end
      end
      SELECTED: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (bit_cnt_q == 4'd8) begin
          push      = 1'b1;
          bit_cnt_d = 4'd0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 4'd1;
        end else if (sclk_fall) begin
          // bit_cnt of 0 on a falling edge means a byte just completed.
          if (bit_cnt_q == 4'd0) shifter_load = 1'b1;
          else                   tx_shift_d   = {tx_shift_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
    if (shifter_load) begin
      tx_shift_d = tx_empty_q ? 8'hFF : tx_buf_q;
      if (!tx_empty_q) tx_empty_d = 1'b1;
    end
    if (tx_load) begin
      tx_buf_d   = tx_data;
      tx_empty_d = 1'b0;
    end
  end

  assign spi_miso = (state_q == SELECTED) & tx_shift_q[7];
  assign tx_empty = tx_empty_q;
  assign busy     = ~cs_s & armed_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       overrun_q, rx_pop, rx_accept;

  assign rx_pop    = rx_read & (count_q != 3'd0);
  assign rx_accept = push & ((count_q != 3'd4) | rx_pop);

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= 8'h00;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      if (rx_accept) begin
        fifo_q[wr_ptr_q] <= rx_shift_q;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (rx_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, rx_accept} - {2'b00, rx_pop};
      if (push && !rx_accept) overrun_q <= 1'b1;
      else if (clear_overrun) overrun_q <= 1'b0;
    end
  end

  assign rx_data  = fifo_q[rd_ptr_q];
  assign rx_valid = (count_q != 3'd0);
  assign overrun  = overrun_q;
`else
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       rx_pop;

  assign rx_pop = rx_read & rx_valid_q;

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (clear_overrun) overrun_d = 1'b0;
    if (push) begin
      if (!rx_valid_q || rx_pop) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_pop) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
`endif

endmodule
`default_nettype wire
